multi_freq_counter: RTL and testbench

//  Parametrised multi-channel frequency counter with an internal gate timer.

---
 rtl/multi_freq_counter.sv | 223 ++++++++++++++++++++++
 tb/tb_multi_freq_counter.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_freq_counter.sv
// ============================================================================
// multi_freq_counter
// ----------------------------------------------------------------------------
// Multi-channel frequency counter with an internal gate timer.
//
// Every channel input is passed through a synchroniser chain and one extra
// delay flop. An edge detector compares the synchronised sample with the
// delayed sample and counts rising, falling or both edges. Edges are counted
// over a window of exactly GATE_CYCLES clocks. After the window, one dead
// LATCH cycle copies the per-channel counts and sticky overflow flags to the
// outputs, together with a one-cycle valid strobe.
//
// A window is started either by a single-shot start request or, in
// continuous mode, back to back with a period of GATE_CYCLES+1 clocks.
// Dropping enable aborts a running window without publishing a result.
//
// Parameters
//   NUM_CH       number of measured channels (>= 1)
//   CNT_W        per-channel counter width in bits
//   GATE_CYCLES  window length in clock cycles (>= 2)
//   SYNC_STAGES  synchroniser flops per channel (>= 2)
//
// Ports
//   clk         system clock, all logic on the rising edge
//   rst         asynchronous active-low reset (0 = reset)
//   signal_in   asynchronous channel inputs, bit i = channel i
//   enable      0 aborts a window and holds the block in IDLE
//   start       single-shot request, only looked at in IDLE
//   continuous  1 = run back-to-back windows while enable is high
//   edge_sel    00 rise, 01 fall, 10 both, 11 rise (change only in IDLE)
//   count_out   latched counts, channel i at [i*CNT_W +: CNT_W]
//   overflow    latched per-channel saturation flags
//   valid       one-cycle pulse when count_out/overflow have been updated
//   busy        high while a window or the latch cycle is in progress
// ============================================================================
module multi_freq_counter #(
    parameter int NUM_CH      = 2,
    parameter int CNT_W       = 28,
    parameter int GATE_CYCLES = 50000000,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       signal_in,
    input  logic                    enable,
    input  logic                    start,
    input  logic                    continuous,
    input  logic [1:0]              edge_sel,
    output logic [NUM_CH*CNT_W-1:0] count_out,
    output logic [NUM_CH-1:0]       overflow,
    output logic                    valid,
    output logic                    busy
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int TIMER_W = $clog2(GATE_CYCLES);

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(GATE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);
    localparam logic [CNT_W-1:0]   CNT_MAX    = '1;
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_MEASURE = 2'd1;
    localparam logic [1:0] ST_LATCH   = 2'd2;

    // ------------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------------
    logic [1:0]                          r_state;
    logic [TIMER_W-1:0]                  r_timer;
    logic                                r_valid;
    logic [NUM_CH-1:0][CNT_W-1:0]        r_count_out;
    logic [NUM_CH-1:0]                   r_overflow;

    logic [NUM_CH-1:0][SYNC_STAGES-1:0]  r_sync;
    logic [NUM_CH-1:0]                   r_dly;
    logic [NUM_CH-1:0][CNT_W-1:0]        r_cnt;
    logic [NUM_CH-1:0]                   r_ovf;

    logic [NUM_CH-1:0]                   w_synced;
    logic [NUM_CH-1:0]                   w_edge;
    logic                                w_start_meas;
    logic                                w_abort;
    logic                                w_count_en;
    logic                                w_latch;
    logic                                w_clear;

    // ------------------------------------------------------------------------
    // Input synchronisers plus one delay flop per channel. Bit 0 of each
    // chain is the metastability-exposed flop; the top bit is the first
    // sample that is safe to use in logic.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= '0;
            r_dly  <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], signal_in[i]};
                r_dly[i]  <= r_sync[i][SYNC_STAGES-1];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Edge detection. Edge mode 11 deliberately falls back to rising edges.
    // ------------------------------------------------------------------------
    always_comb begin
        w_synced = '0;
        w_edge   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_synced[i] = r_sync[i][SYNC_STAGES-1];
            case (edge_sel)
                2'b01:   w_edge[i] = ~w_synced[i] &  r_dly[i];
                2'b10:   w_edge[i] =  w_synced[i] ^  r_dly[i];
                default: w_edge[i] =  w_synced[i] & ~r_dly[i];
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // FSM decode shared by the controller and the channel counters.
    // Counters are cleared whenever a window starts, is aborted, or its
    // result has just been copied out, so each window begins from zero.
    // ------------------------------------------------------------------------
    always_comb begin
        w_start_meas = (r_state == ST_IDLE) && enable && (start || continuous);
        w_abort      = (r_state == ST_MEASURE) && !enable;
        w_count_en   = (r_state == ST_MEASURE) && enable;
        w_latch      = (r_state == ST_LATCH);
        w_clear      = w_start_meas || w_abort || w_latch;
    end

    // ------------------------------------------------------------------------
    // Per-channel saturating edge counters with sticky overflow flags.
    // Once a counter sits at its maximum, any further edge only sets the
    // flag, so the count never wraps back to a small value.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
            r_ovf <= '0;
        end else if (w_clear) begin
            r_cnt <= '0;
            r_ovf <= '0;
        end else if (w_count_en) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_edge[i]) begin
                    if (r_cnt[i] == CNT_MAX) begin
                        r_ovf[i] <= 1'b1;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + CNT_ONE;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Measurement controller. MEASURE runs the timer from 0 to GATE_CYCLES-1,
    // the single LATCH cycle publishes the result, and in continuous mode
    // LATCH hands straight over to the next MEASURE so the window period is
    // GATE_CYCLES+1 clocks. An abort returns to IDLE without touching the
    // published outputs.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_timer     <= '0;
            r_valid     <= 1'b0;
            r_count_out <= '0;
            r_overflow  <= '0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start_meas) begin
                        r_state <= ST_MEASURE;
                        r_timer <= '0;
                    end
                end
                ST_MEASURE: begin
                    if (!enable) begin
                        r_state <= ST_IDLE;
                        r_timer <= '0;
                    end else if (r_timer == TIMER_LAST) begin
                        r_state <= ST_LATCH;
                        r_timer <= '0;
                    end else begin
                        r_timer <= r_timer + TIMER_ONE;
                    end
                end
                ST_LATCH: begin
                    r_count_out <= r_cnt;
                    r_overflow  <= r_ovf;
                    r_valid     <= 1'b1;
                    r_timer     <= '0;
                    if (enable && continuous) begin
                        r_state <= ST_MEASURE;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_timer <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign count_out = r_count_out;
    assign overflow  = r_overflow;
    assign valid     = r_valid;
    assign busy      = (r_state == ST_MEASURE) || (r_state == ST_LATCH);

endmodule

// File: tb/tb_multi_freq_counter.sv
// ============================================================================
// tb_multi_freq_counter
// ----------------------------------------------------------------------------
// Bench for multi_freq_counter. Two instances share every input: one with
// 8-bit counters and one with 4-bit counters, so saturation and overflow are
// exercised on the same stimulus that drives the wide instance.
// ============================================================================
`timescale 1ns/1ps
module tb_multi_freq_counter;

    localparam int NUM_CH   = 2;
    localparam int CNT_W    = 8;
    localparam int CNT_W_S  = 4;
    localparam int GATE     = 100;
    localparam int SYNC     = 2;
    localparam int HIST_LEN = 16384;

    typedef struct {
        logic [1:0] sel;
        int         half0;
        int         half1;
        int         exp0;
        int         exp1;
        logic [1:0] expOv;
        int         expS0;
        int         expS1;
        logic [1:0] expOvS;
    } vecT;

    logic                     clk        = 1'b0;
    logic                     rst        = 1'b0;
    logic [NUM_CH-1:0]        signalIn   = '0;
    logic                     enable     = 1'b0;
    logic                     start      = 1'b0;
    logic                     continuous = 1'b0;
    logic [1:0]               edgeSel    = 2'b00;

    logic [NUM_CH*CNT_W-1:0]   countOut;
    logic [NUM_CH-1:0]         overflowOut;
    logic                      validOut;
    logic                      busyOut;
    logic [NUM_CH*CNT_W_S-1:0] countOutS;
    logic [NUM_CH-1:0]         overflowOutS;
    logic                      validOutS;
    logic                      busyOutS;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Half period per channel: 0 holds low, negative is random, k toggles
    // every k clocks.
    int halfPer [NUM_CH] = '{default: 0};

    // Pin value seen at each clock edge (forced to 0 while reset is held,
    // because the synchronisers are held clear then).
    logic [NUM_CH-1:0] hist [HIST_LEN];

    vecT vecs [6];

    multi_freq_counter #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .GATE_CYCLES(GATE), .SYNC_STAGES(SYNC)
    ) dut (
        .clk(clk), .rst(rst), .signal_in(signalIn), .enable(enable),
        .start(start), .continuous(continuous), .edge_sel(edgeSel),
        .count_out(countOut), .overflow(overflowOut), .valid(validOut),
        .busy(busyOut)
    );

    multi_freq_counter #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W_S), .GATE_CYCLES(GATE), .SYNC_STAGES(SYNC)
    ) dutSmall (
        .clk(clk), .rst(rst), .signal_in(signalIn), .enable(enable),
        .start(start), .continuous(continuous), .edge_sel(edgeSel),
        .count_out(countOutS), .overflow(overflowOutS), .valid(validOutS),
        .busy(busyOutS)
    );

    always #5 clk = ~clk;

    // Edge counter plus pin history, both indexed by edge number.
    always @(posedge clk) begin
        if (cyc + 1 < HIST_LEN) begin
            hist[cyc + 1] <= rst ? signalIn : '0;
        end
        cyc <= cyc + 1;
    end

    // Channel waveform generator, changes pins away from the sampling edge.
    initial begin
        forever begin
            @(negedge clk);
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (halfPer[ch] == 0) begin
                    signalIn[ch] = 1'b0;
                end else if (halfPer[ch] < 0) begin
                    signalIn[ch] = 1'($urandom_range(0, 1));
                end else begin
                    signalIn[ch] = 1'((cyc / halfPer[ch]) % 2);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Number of qualifying pin transitions inside the window that opens at
    // edge firstEdge. A pin value captured at edge m is compared against the
    // value from edge m-1 during clock cycle m+SYNC-1.
    function automatic int rawEdges(input int firstEdge, input int ch, input logic [1:0] sel);
        int   total;
        logic older;
        logic newer;
        total = 0;
        for (int n = firstEdge; n < firstEdge + GATE; n++) begin
            older = hist[n - SYNC][ch];
            newer = hist[n - SYNC + 1][ch];
            case (sel)
                2'b01:   if (older && !newer) total++;
                2'b10:   if (older != newer) total++;
                default: if (!older && newer) total++;
            endcase
        end
        return total;
    endfunction

    task automatic checkAgainstModel(input string tag, input int firstEdge, input logic [1:0] sel);
        int raw;
        int cap;
        int capS;
        cap  = (1 << CNT_W) - 1;
        capS = (1 << CNT_W_S) - 1;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            raw = rawEdges(firstEdge, ch, sel);
            checkOutput($sformatf("%s model ch%0d count", tag, ch),
                        longint'(countOut[ch*CNT_W +: CNT_W]), (raw > cap) ? cap : raw);
            checkOutput($sformatf("%s model ch%0d ovf", tag, ch),
                        longint'(overflowOut[ch]), (raw > cap) ? 1 : 0);
            checkOutput($sformatf("%s model4 ch%0d count", tag, ch),
                        longint'(countOutS[ch*CNT_W_S +: CNT_W_S]), (raw > capS) ? capS : raw);
            checkOutput($sformatf("%s model4 ch%0d ovf", tag, ch),
                        longint'(overflowOutS[ch]), (raw > capS) ? 1 : 0);
        end
    endtask

    // Called at #1 after edge firstEdge. pokeKind 1 pulses start at
    // firstEdge+pokeAt (must be ignored), pokeKind 2 drops continuous there.
    task automatic waitForValid(input string tag, input int firstEdge, input logic [1:0] sel,
                                input bit expBusyAfter, input int pokeAt, input int pokeKind);
        int validEdge;
        int earlyValids;
        int busyGaps;
        validEdge   = firstEdge + GATE + 1;
        earlyValids = 0;
        busyGaps    = 0;
        while (cyc < validEdge) begin
            @(posedge clk);
            #1;
            if (pokeKind == 1) start = (cyc == firstEdge + pokeAt);
            if (pokeKind == 2 && cyc == firstEdge + pokeAt) continuous = 1'b0;
            if (cyc < validEdge) begin
                if (validOut || validOutS) earlyValids++;
                if (!busyOut || !busyOutS) busyGaps++;
            end
        end
        start = 1'b0;
        checkOutput({tag, " early valid cycles"}, earlyValids, 0);
        checkOutput({tag, " busy gaps"}, busyGaps, 0);
        checkOutput({tag, " valid"}, longint'(validOut), 1);
        checkOutput({tag, " valid4"}, longint'(validOutS), 1);
        checkOutput({tag, " busy at valid"}, longint'(busyOut), longint'(expBusyAfter));
        checkAgainstModel(tag, firstEdge, sel);
    endtask

    task automatic pulseStart(output int firstEdge);
        start = 1'b1;
        @(posedge clk);
        #1;
        firstEdge = cyc;
        start = 1'b0;
    endtask

    task automatic applyStimulus(input vecT v, input string tag);
        int firstEdge;
        edgeSel    = v.sel;
        halfPer[0] = v.half0;
        halfPer[1] = v.half1;
        repeat (5) @(posedge clk);
        #1;
        pulseStart(firstEdge);
        waitForValid(tag, firstEdge, v.sel, 1'b0, -1, 0);
        checkOutput({tag, " ch0"}, longint'(countOut[0 +: CNT_W]), v.exp0);
        checkOutput({tag, " ch1"}, longint'(countOut[CNT_W +: CNT_W]), v.exp1);
        checkOutput({tag, " ovf"}, longint'(overflowOut), longint'(v.expOv));
        checkOutput({tag, " ch0 w4"}, longint'(countOutS[0 +: CNT_W_S]), v.expS0);
        checkOutput({tag, " ch1 w4"}, longint'(countOutS[CNT_W_S +: CNT_W_S]), v.expS1);
        checkOutput({tag, " ovf w4"}, longint'(overflowOutS), longint'(v.expOvS));
        @(posedge clk);
        #1;
        checkOutput({tag, " valid one cycle"}, longint'(validOut), 0);
    endtask

    initial begin
        int firstEdge;
        int cnt;
        int busyCnt;

        for (int i = 0; i < HIST_LEN; i++) hist[i] = '0;

        //           sel    h0 h1  e0  e1  ov     s0  s1  ovS
        vecs[0] = '{2'b00, 5, 0,  10, 0,   2'b00, 10, 0,  2'b00};
        vecs[1] = '{2'b10, 5, 0,  20, 0,   2'b00, 15, 0,  2'b01};
        vecs[2] = '{2'b01, 5, 0,  10, 0,   2'b00, 10, 0,  2'b00};
        vecs[3] = '{2'b00, 1, 2,  50, 25,  2'b00, 15, 15, 2'b11};
        vecs[4] = '{2'b11, 2, 5,  25, 10,  2'b00, 15, 10, 2'b01};
        vecs[5] = '{2'b10, 0, 1,  0,  100, 2'b00, 0,  15, 2'b10};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset count", longint'(countOut), 0);
        checkOutput("reset ovf", longint'(overflowOut), 0);
        checkOutput("reset valid", longint'(validOut), 0);
        checkOutput("reset busy", longint'(busyOut), 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        enable = 1'b1;

        // Table-driven single-shot windows
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i], $sformatf("row%0d", i));
        end

        // Start while busy must not restart or extend the window
        edgeSel    = 2'b00;
        halfPer[0] = 5;
        halfPer[1] = 2;
        repeat (5) @(posedge clk);
        #1;
        pulseStart(firstEdge);
        waitForValid("restart", firstEdge, 2'b00, 1'b0, 40, 1);
        cnt = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (validOut) cnt++;
        end
        checkOutput("restart extra valid", cnt, 0);

        // Start with enable low is ignored
        enable  = 1'b0;
        start   = 1'b1;
        busyCnt = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (busyOut) busyCnt++;
        end
        start = 1'b0;
        checkOutput("start without enable busy", busyCnt, 0);
        enable = 1'b1;
        @(posedge clk);
        #1;

        // Continuous: three windows, continuous dropped in the third
        continuous = 1'b1;
        @(posedge clk);
        #1;
        firstEdge = cyc;
        for (int w = 0; w < 3; w++) begin
            waitForValid($sformatf("cont w%0d", w), firstEdge, 2'b00, (w < 2),
                         (w == 2) ? 50 : -1, (w == 2) ? 2 : 0);
            checkOutput($sformatf("cont w%0d ch0", w), longint'(countOut[0 +: CNT_W]), 10);
            checkOutput($sformatf("cont w%0d ch1", w), longint'(countOut[CNT_W +: CNT_W]), 25);
            firstEdge = firstEdge + GATE + 1;
        end
        cnt     = 0;
        busyCnt = 0;
        repeat (120) begin
            @(posedge clk);
            #1;
            if (validOut) cnt++;
            if (busyOut) busyCnt++;
        end
        checkOutput("cont stop valid", cnt, 0);
        checkOutput("cont stop busy", busyCnt, 0);

        // Abort at timer 50: outputs keep the previous result
        pulseStart(firstEdge);
        while (cyc < firstEdge + 50) begin
            @(posedge clk);
            #1;
        end
        enable = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("abort busy", longint'(busyOut), 0);
        cnt = 0;
        repeat (120) begin
            @(posedge clk);
            #1;
            if (validOut || validOutS) cnt++;
        end
        checkOutput("abort no valid", cnt, 0);
        checkOutput("abort hold ch0", longint'(countOut[0 +: CNT_W]), 10);
        checkOutput("abort hold ch1", longint'(countOut[CNT_W +: CNT_W]), 25);
        enable = 1'b1;

        // Reset mid-window at timer 30
        pulseStart(firstEdge);
        while (cyc < firstEdge + 30) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        #1;
        checkOutput("midreset count", longint'(countOut), 0);
        checkOutput("midreset ovf", longint'(overflowOut), 0);
        checkOutput("midreset count w4", longint'(countOutS), 0);
        checkOutput("midreset valid", longint'(validOut), 0);
        checkOutput("midreset busy", longint'(busyOut), 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(vecs[0], "after reset");

        // Randomised windows against the pin-history model
        for (int r = 0; r < 8; r++) begin
            edgeSel = 2'($urandom_range(0, 3));
            for (int ch = 0; ch < NUM_CH; ch++) begin
                halfPer[ch] = int'($urandom_range(0, 8)) - 1;
            end
            repeat (5) @(posedge clk);
            #1;
            pulseStart(firstEdge);
            waitForValid($sformatf("rand%0d", r), firstEdge, edgeSel, 1'b0,
                         int'($urandom_range(10, 90)), int'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
